// File: rtl/bnn_tx_pkg.sv
// Shared types and helpers for the BNN result return path.
// Holds the transmitter state encoding and the counter width helper.
package bnn_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    WAIT_ACK
  } tx_state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for a single asynchronous control bit.
// The output is the last flop of the chain; the chain clears on reset.
module bit_sync #(
  parameter int STAGES = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/bnn_result_tx.sv
// Serial return path: shifts a result word out MSB-first with a bit clock
// and even parity, then waits for a synchronized host ack or a timeout.
module bnn_result_tx
  import bnn_tx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CLK_DIV     = 4,
  parameter int SYNC_STAGES = 3,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  output logic              ready,
  output logic              tx_data,
  output logic              tx_clk,
  output logic              tx_frame,
  input  logic              async_ack_in,
  output logic              done,
  output logic              timeout
);

  localparam int BW   = cnt_w(DATA_W);
  localparam int DVW  = cnt_w(CLK_DIV);
  localparam int TW   = cnt_w(ACK_TIMEOUT);
  localparam int HALF = CLK_DIV / 2;

  tx_state_t         state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_sh;
  logic              parity_q;
  logic [BW-1:0]     bit_q;
  logic [DVW-1:0]    div_q;
  logic [DVW-1:0]    div_nx;
  logic [TW-1:0]     to_q;
  logic              ack_sync;
  logic              ack_prev_q;
  logic              ack_rise_q;
  logic              ready_q;
  logic              tx_data_q;
  logic              tx_clk_q;
  logic              tx_frame_q;
  logic              done_q;
  logic              timeout_q;
  logic              div_end;
  logic              bit_end;
  logic              to_end;

  bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (async_ack_in),
    .q_o    (ack_sync)
  );

  assign shreg_sh = shreg_q << 1;
  assign div_nx   = div_q + DVW'(1);
  assign div_end  = (div_q == DVW'(CLK_DIV - 1));
  assign bit_end  = (bit_q == BW'(DATA_W - 1));
  assign to_end   = (to_q == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      parity_q   <= 1'b0;
      bit_q      <= '0;
      div_q      <= '0;
      to_q       <= '0;
      ack_prev_q <= 1'b0;
      ack_rise_q <= 1'b0;
      ready_q    <= 1'b1;
      tx_data_q  <= 1'b0;
      tx_clk_q   <= 1'b0;
      tx_frame_q <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      // Edge is registered, adding one cycle after the synchronizer.
      ack_prev_q <= ack_sync;
      ack_rise_q <= ack_sync & ~ack_prev_q;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ready_q && load) begin
            state_q    <= SHIFT;
            shreg_q    <= load_data;
            parity_q   <= ^load_data;
            bit_q      <= '0;
            div_q      <= '0;
            ready_q    <= 1'b0;
            tx_frame_q <= 1'b1;
            tx_data_q  <= load_data[DATA_W-1];
            tx_clk_q   <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        SHIFT: begin
          if (div_end) begin
            div_q    <= '0;
            tx_clk_q <= 1'b0;
            if (bit_end) begin
              state_q   <= PARITY;
              tx_data_q <= parity_q;
            end else begin
              bit_q     <= bit_q + BW'(1);
              shreg_q   <= shreg_sh;
              tx_data_q <= shreg_sh[DATA_W-1];
            end
          end else begin
            div_q    <= div_nx;
            tx_clk_q <= (div_nx >= DVW'(HALF));
          end
        end
        PARITY: begin
          if (div_end) begin
            state_q    <= WAIT_ACK;
            div_q      <= '0;
            to_q       <= '0;
            tx_frame_q <= 1'b0;
            tx_data_q  <= 1'b0;
            tx_clk_q   <= 1'b0;
          end else begin
            div_q    <= div_nx;
            tx_clk_q <= (div_nx >= DVW'(HALF));
          end
        end
        WAIT_ACK: begin
          if (ack_rise_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else if (to_end) begin
            state_q   <= IDLE;
            timeout_q <= 1'b1;
          end else begin
            to_q <= to_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready    = ready_q;
  assign tx_data  = tx_data_q;
  assign tx_clk   = tx_clk_q;
  assign tx_frame = tx_frame_q;
  assign done     = done_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_bnn_result_tx.sv
// Bench for bnn_result_tx: timeline reference model plus directed scenarios
// and randomized frames with random ack timing.
module tb_bnn_result_tx;

  localparam int DW = 8;
  localparam int CD = 4;
  localparam int SS = 3;
  localparam int AT = 64;
  localparam int FL = (DW + 1) * CD;
  localparam int HN = 16384;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          load = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          async_ack_in = 1'b0;
  logic          ready, tx_data, tx_clk, tx_frame, done, timeout;

  int n_run = 0;
  int n_fail = 0;

  bnn_result_tx #(
    .DATA_W(DW), .CLK_DIV(CD), .SYNC_STAGES(SS), .ACK_TIMEOUT(AT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .load_data(load_data),
    .ready(ready), .tx_data(tx_data), .tx_clk(tx_clk),
    .tx_frame(tx_frame), .async_ack_in(async_ack_in),
    .done(done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Reference timeline: mode 0 idle/ready, 1 frame or waiting, 2 pulse.
  int            cyc = 0;
  int            mode = 0;
  int            t0 = 0;
  int            pk = 0;
  logic [DW-1:0] word = '0;
  logic          ah [HN];
  logic          ld_s, ak_s, rn_s;
  logic [DW-1:0] ldd_s;
  int            w, d, b;
  logic [5:0]    exp_v;

  // Monitor observations used by the directed checks.
  logic [DW:0] bits = '0;
  int nbits = 0, flen = 0, rdy_in = 0, fstart = 0;
  int nframes = 0, wstart = 0, npulse = 0, pcyc = 0, pkind = 0;
  logic pframe = 1'b0, pclk = 1'b0;
  int fr0 = 0, pu0 = 0;

  initial for (int i = 0; i < HN; i++) ah[i] = 1'b0;

  function automatic logic arr(input int k);
    if (k - SS - 1 < 0) return 1'b0;
    return ah[(k - SS) % HN] && !ah[(k - SS - 1) % HN];
  endfunction

  always @(posedge clk) begin
    ld_s = load; ldd_s = load_data; ak_s = async_ack_in; rn_s = reset_n;
    #1;
    cyc++;
    ah[cyc % HN] = rn_s ? ak_s : 1'b0;
    if (!rn_s) begin
      mode = 0;
    end else begin
      case (mode)
        0: if (ld_s) begin mode = 1; t0 = cyc; word = ldd_s; end
        2: mode = 0;
        default: begin
          w = cyc - 1 - t0 - FL;
          if (w >= 0) begin
            if (arr(cyc - 1)) begin mode = 2; pk = 1; end
            else if (w == AT - 1) begin mode = 2; pk = 2; end
          end
        end
      endcase
    end
    // exp_v = {ready, tx_frame, tx_data, tx_clk, done, timeout}
    exp_v = {(mode == 0), 5'b0};
    if (mode == 2) exp_v[1:0] = (pk == 1) ? 2'b10 : 2'b01;
    if (mode == 1) begin
      d = cyc - t0;
      if (d < FL) begin
        b = d / CD;
        exp_v[4] = 1'b1;
        exp_v[3] = (b < DW) ? word[DW-1-b] : ^word;
        exp_v[2] = ((d % CD) >= CD / 2);
      end
    end
    chk($sformatf("outputs@%0d", cyc),
        int'({ready, tx_frame, tx_data, tx_clk, done, timeout}), int'(exp_v));
    if (rn_s) begin
      if (tx_frame && !pframe) begin
        flen = 0; nbits = 0; bits = '0; fstart = cyc; rdy_in = 0;
      end
      if (tx_frame) begin flen++; if (ready) rdy_in++; end
      if (tx_clk && !pclk) begin bits = {bits[DW-1:0], tx_data}; nbits++; end
      if (!tx_frame && pframe) begin nframes++; wstart = cyc; end
      if (done || timeout) begin
        npulse++; pcyc = cyc; pkind = done ? 1 : 2;
      end
    end
    pframe = tx_frame;
    pclk = tx_clk;
  end

  task automatic send(input logic [DW-1:0] v);
    int k = 0;
    while (!ready && k < 300) begin @(negedge clk); k++; end
    chk("ready_wait", int'(ready), 1);
    fr0 = nframes; pu0 = npulse;
    load = 1'b1; load_data = v;
    @(negedge clk);
    load = 1'b0; load_data = DW'($urandom);
  endtask

  task automatic wait_frame_end();
    int k = 0;
    while (nframes == fr0 && k < 300) begin @(negedge clk); k++; end
    chk("frame_end_wait", int'(nframes > fr0), 1);
  endtask

  task automatic wait_pulse();
    int k = 0;
    while (npulse == pu0 && k < 300) begin @(negedge clk); k++; end
    chk("pulse_wait", int'(npulse > pu0), 1);
  endtask

  task automatic chk_frame(string nm, input logic [DW:0] exp_bits);
    chk({nm, "_bits"}, int'(bits), int'(exp_bits));
    chk({nm, "_nbits"}, nbits, DW + 1);
    chk({nm, "_len"}, flen, FL);
    chk({nm, "_ready_in_frame"}, rdy_in, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dly, pulses_before;
    logic [DW-1:0] v;
    repeat (3) @(negedge clk);
    chk("rst_state", int'({ready, tx_frame, tx_data, tx_clk, done, timeout}),
        6'b100000);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: A5 frame, bits 1,0,1,0,0,1,0,1 then parity 0
    send(8'hA5);
    wait_frame_end();
    chk_frame("a5", {8'hA5, 1'b0});
    wait_pulse();

    // 2: 07 has odd ones, parity 1; ack 10 cycles into wait
    send(8'h07);
    wait_frame_end();
    chk_frame("07", {8'h07, 1'b1});
    chk("07_parity", int'(bits[0]), 1);
    repeat (10) @(negedge clk);
    async_ack_in = 1'b1;
    dly = cyc + 1;
    wait_pulse();
    chk("ack_kind", pkind, 1);
    chk("ack_latency", pcyc - dly, 4);
    @(negedge clk);
    chk("ready_after_done", int'(ready), 1);
    async_ack_in = 1'b0;
    repeat (6) @(negedge clk);

    // 3: timeout at wait cycle 64, then immediate reload
    send(8'h81);
    wait_frame_end();
    wait_pulse();
    chk("to_kind", pkind, 2);
    chk("to_cycle", pcyc - wstart, 64);
    send(8'h3C);
    chk("reload_start", fstart - pcyc, 2);
    wait_frame_end();
    chk_frame("3c", {8'h3C, 1'b0});
    wait_pulse();

    // 4: load during an active frame is dropped
    send(8'hA5);
    repeat (5) @(negedge clk);
    load = 1'b1; load_data = 8'hFF;
    @(negedge clk);
    load = 1'b0;
    wait_frame_end();
    chk_frame("ign", {8'hA5, 1'b0});
    wait_pulse();

    // 5: reset mid-frame
    send(8'hC7);
    repeat (15) @(negedge clk);
    pulses_before = npulse;
    reset_n = 1'b0;
    #1;
    chk("mid_rst", int'({ready, tx_frame, tx_data, tx_clk, done, timeout}),
        6'b100000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_no_pulse", npulse, pulses_before);
    send(8'h5A);
    wait_frame_end();
    chk_frame("5a", {8'h5A, 1'b0});
    wait_pulse();

    // 6a: ack held high across the frame gives timeout
    async_ack_in = 1'b1;
    repeat (10) @(negedge clk);
    send(8'h33);
    wait_frame_end();
    wait_pulse();
    chk("held_ack_kind", pkind, 2);
    async_ack_in = 1'b0;
    repeat (6) @(negedge clk);

    // 6b: ack edge arriving on the expiry cycle wins
    send(8'hC3);
    wait_frame_end();
    repeat (59) @(negedge clk);
    async_ack_in = 1'b1;
    wait_pulse();
    chk("tie_kind", pkind, 1);
    chk("tie_cycle", pcyc - wstart, 64);
    async_ack_in = 1'b0;
    repeat (6) @(negedge clk);

    // Randomized frames and ack timing
    for (int it = 0; it < 24; it++) begin
      v = DW'($urandom);
      send(v);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 30)) @(negedge clk);
        load = 1'b1; load_data = DW'($urandom);
        @(negedge clk);
        load = 1'b0;
      end
      wait_frame_end();
      chk_frame("rnd", {v, ^v});
      dly = $urandom_range(0, 72);
      repeat (dly) @(negedge clk);
      if (dly < 68) async_ack_in = 1'b1;
      wait_pulse();
      repeat ($urandom_range(1, 4)) @(negedge clk);
      async_ack_in = 1'b0;
      repeat ($urandom_range(4, 8)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/bnn_result_tx.md
Name: bnn_result_tx

Overview:
Serial transmitter that returns inference results from the BNN core to the external host over TinyTapeout output pins. It is the return path opposite the input synchronizer that brings in the pixel, weight and enable bits. It accepts a parallel result word, shifts it out MSB-first with a generated bit clock and an even-parity bit, then waits for an asynchronous host acknowledge. That acknowledge is synchronized internally, and a timeout covers the case where it never arrives.

Parameters:
DATA_W, 8, payload width in bits (range 1..16)
CLK_DIV, 4, clk cycles per serial bit (must be even, at least 2)
SYNC_STAGES, 3, flop stages in the ack synchronizer (at least 2)
ACK_TIMEOUT, 64, clk cycles to wait in WAIT_ACK before abandoning the frame (at least 1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
load  in  1  request to transmit load_data; sampled at posedge
load_data  in  DATA_W  result word (class index / score)
ready  out  1  high only in IDLE; load is accepted only when ready=1
tx_data  out  1  serial data, MSB first, then parity
tx_clk  out  1  bit clock; host samples tx_data on its rising edge
tx_frame  out  1  high for the whole data+parity frame
async_ack_in  in  1  host acknowledge, asynchronous to clk
done  out  1  1-cycle pulse when the ack is received
timeout  out  1  1-cycle pulse when ACK_TIMEOUT expires

Behaviour:
- Reset values (asynchronous on reset_n low):
  - outputs: ready=1, tx_data=0, tx_clk=0, tx_frame=0, done=0, timeout=0
  - state=IDLE, all counters 0, synchronizer chain and ack_prev cleared
- All outputs are registered.
- States:
  - IDLE -> SHIFT on load=1 (ready is 1 by definition). Capture shreg=load_data and parity=^load_data.
  - SHIFT -> PARITY after DATA_W bit periods.
  - PARITY -> WAIT_ACK after one bit period.
  - WAIT_ACK -> IDLE on ack edge (done=1) or on timeout (timeout=1).
- load outside IDLE is ignored. No queueing; the word is dropped.
- Cycle following acceptance: tx_frame=1, ready=0, tx_data=load_data[DATA_W-1], tx_clk=0.
- Bit period (div_cnt 0..CLK_DIV-1):
  - tx_clk=0 for div_cnt < CLK_DIV/2, otherwise 1.
  - tx_data changes only at div_cnt=0, so it is stable across each tx_clk rising edge.
- Frame length is exactly (DATA_W+1)*CLK_DIV cycles of tx_frame=1.
- Parity bit is even parity: XOR of the payload bits, so the total count of ones is even.
- Entering WAIT_ACK: tx_frame=0, tx_data=0, tx_clk=0, and the timeout counter starts at 0.
- Ack path:
  - async_ack_in passes through the SYNC_STAGES synchronizer, then a rising-edge detect (ack_prev register).
  - Latency from ack rise to done pulse: SYNC_STAGES+1 cycles, measured from the first posedge that samples ack high.
  - Edges outside WAIT_ACK are ignored, but ack_prev keeps tracking every cycle.
  - If the synchronized ack is still high when WAIT_ACK is entered, there is no edge, so the frame times out. The host must drop ack between frames.
- Timeout: asserted when the counter reaches ACK_TIMEOUT-1 with no edge. If the edge and the expiry land in the same cycle, ack wins: done=1, timeout=0.
- done and timeout are never high together.
- ready returns to 1 in the cycle after the done or timeout pulse. Back-to-back loads are therefore possible one cycle after ready rises.
- Reset mid-frame aborts immediately with reset values and no partial completion pulse.

Decomposition:
- Package bnn_tx_pkg:
  - tx_state_t enum {IDLE, SHIFT, PARITY, WAIT_ACK}
  - localparam function for counter widths ($clog2 of DATA_W, CLK_DIV, ACK_TIMEOUT)
- Sub-module bit_sync: parameterized SYNC_STAGES single-bit synchronizer with async active-low reset, used for async_ack_in.
- FSM, shifter, divider and timeout counter live in bnn_result_tx.

Test Plan:
1. Defaults. load=1 with load_data=0xA5 for one cycle.
   - Required: tx_frame high for 36 cycles.
   - Bits sampled on tx_clk rising edges: 1,0,1,0,0,1,0,1 then parity 0.
   - ready low throughout.
2. load_data=0x07, then ack raised 10 cycles into WAIT_ACK.
   - Required: parity bit 1.
   - done pulses exactly 4 cycles after the first posedge sampling ack=1.
   - ready=1 on the following cycle.
3. No ack after the frame.
   - Required: timeout pulses on WAIT_ACK cycle 64.
   - done stays 0, return to IDLE.
   - A new load of 0x3C is accepted next cycle and transmits correctly.
4. load pulsed with 0xFF at cycle 5 of an active 0xA5 frame.
   - Required: ignored; 0xA5 frame completes unchanged.
5. reset_n low at cycle 15 of a frame.
   - Required: immediately ready=1, tx_frame=0, tx_data=0, tx_clk=0.
   - No done or timeout pulse; after release a fresh 0x5A frame is correct.
6. Ack held high from before the frame through WAIT_ACK.
   - Required: timeout, not done.
   - Separately, an ack edge timed to land on the expiry cycle must give done=1, timeout=0.
